// File: rtl/hdr_color_pkg.sv
// hdr_color_pkg: constants and types shared by the HDR colour-space stages.
//   - field widths of the HSV pixel format exchanged with the HSV-to-RGB stage
//   - hue anchor points in degrees
//   - encoding of the channel that holds max(r,g,b)
//   - RGB2HSV_LAT: rgb_to_hsv pipeline latency, which HSV-domain stages use
//     to delay their own sidebands into alignment
package hdr_color_pkg;

  localparam int H_W        = 9;
  localparam int S_W        = 11;
  localparam int S_FRAC     = 11;
  localparam int V_W        = 8;

  localparam int HUE_SECTOR = 60;
  localparam int HUE_G      = 120;
  localparam int HUE_B      = 240;
  localparam int HUE_FULL   = 360;

  localparam int RGB2HSV_QW  = 12;
  localparam int RGB2HSV_LAT = RGB2HSV_QW + 3;

  typedef enum logic [1:0] {
    SEL_R = 2'd0,
    SEL_G = 2'd1,
    SEL_B = 2'd2
  } sel_e;

  // Per-pixel fields that ride alongside the dividers until the final stage.
  typedef struct packed {
    logic           neg;  // hue difference was negative
    logic           dz;   // delta == 0 (achromatic)
    sel_e           sel;  // channel holding the maximum
    logic [V_W-1:0] mx;   // maximum channel value
  } hsv_aux_t;

  // Hue of the sector centre owned by the max channel.
  function automatic logic [H_W-1:0] hue_base(input sel_e sel);
    logic [H_W-1:0] base;
    case (sel)
      SEL_R:   base = 9'd0;
      SEL_G:   base = 9'd120;
      SEL_B:   base = 9'd240;
      default: base = 9'd0;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/udiv_pipe.sv
// udiv_pipe: pipelined unsigned restoring divider, one quotient bit per
// stage, MSB first. Stage k register holds the partial remainder, the
// denominator and the quotient bits resolved so far; the trial for bit
// QW-1-k is evaluated between register k and register k+1, and the last
// trial feeds the quotient output directly (caller registers it).
// Quotient is assumed to fit in QW bits (true for both uses in rgb_to_hsv).
// A zero denominator never sets a quotient bit, so the result is 0.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   numer     - NW-bit dividend
//   denom     - DW-bit divisor
//   quotient  - QW-bit quotient, QW register stages after numer/denom
module udiv_pipe #(
  parameter int NW = 19,
  parameter int DW = 8,
  parameter int QW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NW-1:0] numer,
  input  logic [DW-1:0] denom,
  output logic [QW-1:0] quotient
);

  localparam int CW = (NW > DW + QW) ? NW : DW + QW;

  logic [NW-1:0] rem_d [QW];
  logic [NW-1:0] rem_q [QW];
  logic [DW-1:0] den_d [QW];
  logic [DW-1:0] den_q [QW];
  logic [QW-1:0] quo_d [QW];
  logic [QW-1:0] quo_q [QW];

  function automatic logic [CW-1:0] scaled(input logic [DW-1:0] den, input int sh);
    return CW'(den) << sh;
  endfunction

  function automatic logic fits(input logic [NW-1:0] rem, input logic [DW-1:0] den,
                                input int sh);
    return (den != {DW{1'b0}}) && (CW'(rem) >= scaled(den, sh));
  endfunction

  function automatic logic [QW-1:0] qbit(input int sh);
    logic [QW-1:0] one;
    one = {{(QW-1){1'b0}}, 1'b1};
    return one << sh;
  endfunction

  // Trial subtraction for every stage except the last.
  always_comb begin
    rem_d[0] = numer;
    den_d[0] = denom;
    quo_d[0] = {QW{1'b0}};
    for (int k = 0; k < QW - 1; k++) begin
      den_d[k+1] = den_q[k];
      if (fits(rem_q[k], den_q[k], QW - 1 - k)) begin
        rem_d[k+1] = NW'(CW'(rem_q[k]) - scaled(den_q[k], QW - 1 - k));
        quo_d[k+1] = quo_q[k] | qbit(QW - 1 - k);
      end else begin
        rem_d[k+1] = rem_q[k];
        quo_d[k+1] = quo_q[k];
      end
    end
  end

  // Last trial resolves the LSB; its remainder is not needed.
  always_comb begin
    if (fits(rem_q[QW-1], den_q[QW-1], 0)) begin
      quotient = quo_q[QW-1] | qbit(0);
    end else begin
      quotient = quo_q[QW-1];
    end
  end

  // Stage registers.
  always_ff @(posedge clk) begin
    for (int k = 0; k < QW; k++) begin
      if (rst) begin
        rem_q[k] <= {NW{1'b0}};
        den_q[k] <= {DW{1'b0}};
        quo_q[k] <= {QW{1'b0}};
      end else begin
        rem_q[k] <= rem_d[k];
        den_q[k] <= den_d[k];
        quo_q[k] <= quo_d[k];
      end
    end
  end

endmodule

// File: rtl/rgb_to_hsv.sv
// rgb_to_hsv: streaming 8-bit RGB to HSV converter, fixed latency QW+3,
// no backpressure. Output format matches the HSV-to-RGB stage:
// H in degrees 0..359, S unsigned Q0.11 (clamped to 2047), V = max channel.
// Build option: define RGB2HSV_ROUND_EN to make both dividers round to
// nearest instead of truncating; latency and ports are unchanged.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid, r, g, b   - input pixel and qualifier
//   in_sb               - sideband (sync/de), delayed with the pixel
//   out_valid, H, S, V  - output pixel and qualifier
//   out_sb              - sideband aligned with H/S/V
module rgb_to_hsv
  import hdr_color_pkg::*;
#(
  parameter int SB_W = 3,
  parameter int QW   = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [7:0]      r,
  input  logic [7:0]      g,
  input  logic [7:0]      b,
  input  logic [SB_W-1:0] in_sb,
  output logic            out_valid,
  output logic [H_W-1:0]  H,
  output logic [S_W-1:0]  S,
  output logic [V_W-1:0]  V,
  output logic [SB_W-1:0] out_sb
);

  localparam int LAT = QW + 3;
  localparam int SNW = V_W + S_FRAC;
  localparam int HNW = 14;
  localparam logic signed [QW+1:0] HUE_FULL_W = (QW + 2)'(HUE_FULL);

  // stage 1
  logic [V_W-1:0]    mx1_d, mx1_q, mn1_d, mn1_q, mn_rg_s;
  sel_e              sel1_d, sel1_q;
  logic signed [8:0] diff1_d, diff1_q;
  // stage 2
  logic [V_W-1:0]    delta_s;
  logic [8:0]        diff_abs_s;
  logic [HNW-1:0]    h_prod_s;
  logic [SNW-1:0]    s_num2_d, s_num2_q;
  logic [V_W-1:0]    s_den2_d, s_den2_q;
  logic [HNW-1:0]    h_num2_d, h_num2_q;
  logic [V_W-1:0]    h_den2_d, h_den2_q;
  hsv_aux_t          aux2_d, aux2_q;
  // divider span and shift registers
  logic [QW-1:0]               s_quo_s, h_quo_s;
  hsv_aux_t [QW-1:0]           aux_d, aux_q;
  logic [LAT-1:0]              vld_d, vld_q;
  logic [LAT-1:0][SB_W-1:0]    sb_d, sb_q;
  logic [SB_W-1:0]             sb_in_s;
  // final stage
  hsv_aux_t                    aux_f_s;
  logic [H_W-1:0]              base_s, h_fin_s, h_d, h_q;
  logic signed [QW+1:0]        h_sum_s;
  logic [S_W-1:0]              s_fin_s, s_d, s_q;
  logic [V_W-1:0]              v_d, v_q;

  // Stage 1: max/min, owning channel (ties favour r, then g) and signed diff.
  always_comb begin
    mn_rg_s = (r < g) ? r : g;
    mn1_d   = (b < mn_rg_s) ? b : mn_rg_s;
    if (r >= g && r >= b) begin
      mx1_d   = r;
      sel1_d  = SEL_R;
      diff1_d = {1'b0, g} - {1'b0, b};
    end else if (g >= b) begin
      mx1_d   = g;
      sel1_d  = SEL_G;
      diff1_d = {1'b0, b} - {1'b0, r};
    end else begin
      mx1_d   = b;
      sel1_d  = SEL_B;
      diff1_d = {1'b0, r} - {1'b0, g};
    end
  end

  // Stage 2: divider operands and the fields needed after division.
  always_comb begin
    delta_s = mx1_q - mn1_q;
    if (diff1_q[8]) begin
      diff_abs_s = -diff1_q;
    end else begin
      diff_abs_s = diff1_q;
    end
    h_prod_s = {5'd0, diff_abs_s} * 14'(HUE_SECTOR);
`ifdef RGB2HSV_ROUND_EN
    // Half-divisor bias turns truncation into round-to-nearest.
    h_num2_d = h_prod_s + {6'd0, delta_s >> 1};
    s_num2_d = {delta_s, 11'd0} + {11'd0, mx1_q >> 1};
`else
    h_num2_d = h_prod_s;
    s_num2_d = {delta_s, 11'd0};
`endif
    s_den2_d   = mx1_q;
    h_den2_d   = delta_s;
    aux2_d.neg = diff1_q[8];
    aux2_d.dz  = (delta_s == {V_W{1'b0}});
    aux2_d.sel = sel1_q;
    aux2_d.mx  = mx1_q;
  end

  udiv_pipe #(.NW(SNW), .DW(V_W), .QW(QW)) u_s_div (
    .clk      (clk),
    .rst      (rst),
    .numer    (s_num2_q),
    .denom    (s_den2_q),
    .quotient (s_quo_s)
  );

  udiv_pipe #(.NW(HNW), .DW(V_W), .QW(QW)) u_h_div (
    .clk      (clk),
    .rst      (rst),
    .numer    (h_num2_q),
    .denom    (h_den2_q),
    .quotient (h_quo_s)
  );

  // Valid/sideband delay over the full latency; aux delay over the divider span.
  // Sideband of an empty slot is forced to 0 so outputs stay 0 until data.
  always_comb begin
    if (in_valid) begin
      sb_in_s = in_sb;
    end else begin
      sb_in_s = {SB_W{1'b0}};
    end
    vld_d = {vld_q[LAT-2:0], in_valid};
    sb_d  = {sb_q[LAT-2:0], sb_in_s};
    aux_d = {aux_q[QW-2:0], aux2_q};
  end

  // Final stage: hue reassembly with wrap, saturation clamp.
  always_comb begin
    aux_f_s = aux_q[QW-1];
    base_s  = hue_base(aux_f_s.sel);
    if (aux_f_s.neg) begin
      h_sum_s = $signed({{(QW+2-H_W){1'b0}}, base_s}) - $signed({2'b00, h_quo_s});
    end else begin
      h_sum_s = $signed({{(QW+2-H_W){1'b0}}, base_s}) + $signed({2'b00, h_quo_s});
    end
    if (aux_f_s.dz) begin
      h_fin_s = {H_W{1'b0}};
    end else if (h_sum_s < $signed({(QW+2){1'b0}})) begin
      h_fin_s = H_W'(h_sum_s + HUE_FULL_W);
    end else begin
      h_fin_s = h_sum_s[H_W-1:0];
    end
    if (aux_f_s.mx == {V_W{1'b0}}) begin
      s_fin_s = {S_W{1'b0}};
    end else if (s_quo_s > {{(QW-S_W){1'b0}}, {S_W{1'b1}}}) begin
      s_fin_s = {S_W{1'b1}};
    end else begin
      s_fin_s = s_quo_s[S_W-1:0];
    end
    // Output data only moves with a valid pixel, so it stays 0 after reset.
    if (vld_q[LAT-2]) begin
      h_d = h_fin_s;
      s_d = s_fin_s;
      v_d = aux_f_s.mx;
    end else begin
      h_d = h_q;
      s_d = s_q;
      v_d = v_q;
    end
  end

  // Pipeline registers for all stages owned by this module.
  always_ff @(posedge clk) begin
    if (rst) begin
      mx1_q    <= {V_W{1'b0}};
      mn1_q    <= {V_W{1'b0}};
      sel1_q   <= SEL_R;
      diff1_q  <= 9'sd0;
      s_num2_q <= {SNW{1'b0}};
      s_den2_q <= {V_W{1'b0}};
      h_num2_q <= {HNW{1'b0}};
      h_den2_q <= {V_W{1'b0}};
      aux2_q   <= '0;
      aux_q    <= '0;
      vld_q    <= {LAT{1'b0}};
      sb_q     <= '0;
      h_q      <= {H_W{1'b0}};
      s_q      <= {S_W{1'b0}};
      v_q      <= {V_W{1'b0}};
    end else begin
      mx1_q    <= mx1_d;
      mn1_q    <= mn1_d;
      sel1_q   <= sel1_d;
      diff1_q  <= diff1_d;
      s_num2_q <= s_num2_d;
      s_den2_q <= s_den2_d;
      h_num2_q <= h_num2_d;
      h_den2_q <= h_den2_d;
      aux2_q   <= aux2_d;
      aux_q    <= aux_d;
      vld_q    <= vld_d;
      sb_q     <= sb_d;
      h_q      <= h_d;
      s_q      <= s_d;
      v_q      <= v_d;
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_sb    = sb_q[LAT-1];
  assign H         = h_q;
  assign S         = s_q;
  assign V         = v_q;

endmodule

// File: doc/rgb_to_hsv.md
Name: rgb_to_hsv

Overview:
Streaming RGB-to-HSV converter: the stage directly upstream of the HSV-to-RGB reconstruction in the HDR video path. Tone/saturation processing operates between the two stages.
- Consumes one 8-bit RGB pixel per clock.
- Produces H (degrees), S (fixed point) and V in exactly the format the HSV-to-RGB stage accepts.
- Fully pipelined with fixed latency. No backpressure.

Parameters:
SB_W, 3, width of the sideband bus (e.g. hsync/vsync/de) delayed alongside the pixel
QW, 12, quotient bits per divider, which equals the number of divider pipeline stages

Ports:
clk  in  1  clock (one clock; all logic on the rising edge)
rst  in  1  synchronous reset, active-high
in_valid  in  1  input pixel qualifier
r  in  8  red
g  in  8  green
b  in  8  blue
in_sb  in  SB_W  sideband, sampled with the pixel
out_valid  out  1  output qualifier
H  out  9  hue in degrees, 0..359
S  out  11  saturation, unsigned Q0.11 (2047 is approximately 1.0)
V  out  8  value
out_sb  out  SB_W  sideband, aligned with H/S/V

Behaviour:
- Reset: synchronous, active-high. While rst is high at a clock edge, out_valid, H, S, V and out_sb clear to 0, and every internal valid bit clears.
  - In-flight pixels are discarded.
  - The first out_valid after reset follows the first in_valid sampled with rst low, by exactly LAT cycles.
- Latency: LAT = QW + 3 = 15 cycles for H, S, V, out_valid and out_sb together.
  - No bubbles are inserted or removed.
  - Data outputs are don't-care when out_valid = 0, except after reset, when they are 0.
- Stage 1 (register): mx = max(r,g,b); mn = min(r,g,b); sel = channel of mx.
  - Tie priority is r > g > b.
  - Register diff: g-b for sel=r, b-r for sel=g, r-g for sel=b. diff is signed, 9 bits.
- Stage 2 (register):
  - delta = mx - mn.
  - S numerator: delta << 11 (19 bits); S denominator: mx.
  - H numerator: 60*|diff| (14 bits); H denominator: delta.
  - Carry the diff sign and the base hue: 0 for r, 120 for g, 240 for b.
- Stages 3..QW+2: two restoring dividers, unsigned, one quotient bit per stage, MSB first.
  - Quotient width is QW for both dividers, so latencies match.
  - A zero denominator yields quotient 0 and never X.
- Final stage (register):
  - hq = quotient of the H divider.
  - H = base + hq if the sign is non-negative; otherwise base - hq. If base - hq is negative, add 360.
  - If delta = 0, then H = 0.
  - S = min(quotient of the S divider, 2047). If mx = 0, then S = 0.
  - V = mx.
- Range guarantees: H stays in 0..359 and 360 is never produced. S stays within 11 bits with no wrap.
- Valid/sideband pipeline: shift registers of length LAT. A gap in in_valid propagates as a gap in out_valid.

Optional Feature:
Macro RGB2HSV_ROUND_EN.
- Defined: both dividers round to nearest.
  - delta>>1 is added to the H numerator.
  - mx>>1 is added to the S numerator.
  - The S clamp to 2047 still applies.
- Undefined: both quotients truncate toward zero.
- Latency and interface are identical in both builds.

Decomposition:
- Shared package hdr_color_pkg holds:
  - widths H_W=9, S_W=11, S_FRAC=11, V_W=8
  - HUE_SECTOR=60, HUE_G=120, HUE_B=240, HUE_FULL=360
  - the sel channel encoding
  - the RGB2HSV_LAT constant, which the HSV-domain stages use for alignment
- One natural sub-module: udiv_pipe.
  - Parameters NW, DW, QW; ports clk, rst, numer, denom, quotient.
  - Each stage carries its remainder and denom.
  - Instantiated twice: once for S, once for H.

Test Plan:
- Reset: r=255, g=0, b=0 valid for one cycle (no reset during flight) -> 15 cycles later out_valid=1, H=0, S=2047, V=255. Repeat with (0,255,0) -> H=120, S=2047, V=255; and (0,0,255) -> H=240, S=2047, V=255.
- Gray and black: (128,128,128) -> H=0, S=0, V=128; (0,0,0) -> H=0, S=0, V=0. No X on any output.
- Exact arithmetic: (200,100,50) -> H=20, S=1536, V=200. Tie (200,200,0) -> sel=r, H=60, S=2047, V=200.
- Hue wrap: (255,0,128) -> H=330 (truncated 60*128/255=30), S=2047, V=255. The same value is required under RGB2HSV_ROUND_EN. Also check (10,0,9) -> H=306 without the macro, H=306 with it.
- Streaming: 100 random pixels with random in_valid gaps and an incrementing in_sb. Every output must match the golden model with identical gap pattern and sb alignment at exactly 15-cycle latency.
- Reset mid-stream: assert rst for 1 cycle with 7 pixels in flight -> out_valid=0 and outputs 0 for the following 15 cycles. The next pixel appears exactly 15 cycles after its in_valid.
